mul16_seq: RTL and testbench
============================

// Module: mul16_seq
//
// PURPOSE
//  Multi-cycle 16x16 unsigned multiplier controller built on one shared Add16.
//  Sequences shift-and-add: one Add16 pass per multiplier bit, low 16 bits kept.
//  Sits beside the ALU as the multiply engine; the CPU issues start, waits for done.
//  start/busy/done handshake; result held until the next accepted start.
//
// PARAMETERS
//  EARLY_EXIT  1  1: stop when remaining multiplier bits are all zero; 0: always 16 RUN cycles
//
// PORTS
//  clock   in   1   single clock, all state on rising edge
//  reset   in   1   synchronous, active-high
//  start   in   1   request; sampled only in IDLE
//  a       in   16  multiplicand, captured on accepted start
//  b       in   16  multiplier, captured on accepted start
//  busy    out  1   1 while in RUN
//  done    out  1   1-cycle pulse, result valid
//  out     out  16  product mod 2^16; holds until next DONE
//
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, out=0, internal acc/mcand/mplier/count=0.
//    Reset mid-RUN aborts the operation; no done pulse; out forced to 0.
//  - States: IDLE -> RUN -> DONE -> IDLE. busy=(state==RUN), done=(state==DONE), Moore outputs.
//  - IDLE: start=1 at edge k -> acc<=0, mcand<=a, mplier<=b, count<=0, state<=RUN.
//    start=0 -> remain IDLE. a/b ignored except at the accepting edge.
//  - RUN, each edge: if mplier[0], acc<=Add16(acc,mcand) else acc unchanged;
//    mcand<=mcand<<1 (MSB dropped); mplier<=mplier>>1; count<=count+1.
//    Exit to DONE when count==15, or (EARLY_EXIT && (mplier>>1)==0); out<=next acc on that edge.
//  - DONE: done=1 for exactly one cycle, then IDLE unconditionally. start in DONE ignored.
//  - start while busy: ignored, no queueing, operands unchanged.
//  - Latency, EARLY_EXIT=0: accept at edge k, DONE entered at edge k+16, done high k+16..k+17.
//    EARLY_EXIT=1: RUN cycles = index of highest set bit of b + 1 (minimum 1, incl. b=0).
//  - Arithmetic: unsigned, modulo 2^16; Add16 carry-out discarded; no overflow flag.
//  - count is 5 bits wide; never exceeds 15 in RUN.
//  - out changes only on the RUN->DONE edge and on reset.
//
// STRUCTURE
//  - One sub-module: Add16 instance (existing gate-level adder) for acc+mcand; no other adder.
//    count increment may use Inc16 or a behavioural +1; shifts are wiring.
//  - State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and MUL_BITS=16 go in the
//    shared include with the other CPU constants; FSM, registers, mux local to this block.
//
// TESTING  (EARLY_EXIT=0 unless noted; check busy/done/out every cycle)
//  - reset held 2 cycles -> busy=0, done=0, out=0x0000; release, start=0 -> stays IDLE.
//  - a=0x0003, b=0x0005, start 1 cycle -> busy 16 cycles, done 1 cycle, out=0x000F, then IDLE.
//  - a=0xFFFF, b=0xFFFF -> out=0x0001; a=0x0100, b=0x0100 -> out=0x0000 (wrap).
//  - EARLY_EXIT=1: a=0x1234, b=0x0000 -> 1 RUN cycle, out=0x0000; b=0x0004 -> 3 RUN cycles, out=0x48D0.
//  - a=7,b=6 accepted; start pulsed with a=2,b=2 at RUN cycle 5 -> ignored, out=0x002A.
//  - reset asserted at RUN cycle 8 of a=0x0011,b=0x0011 -> next cycle IDLE, out=0, no done pulse.

Source files
------------

// File: rtl/mul16_seq_pkg.sv
// Shared constants for the multiply engine: operand width and FSM state encodings.
package mul16_seq_pkg;

  localparam int MUL_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul16_seq_add16.sv
// 16-bit ripple-carry adder built from generate/propagate terms; carry-out is not formed.
module mul16_seq_add16
  import mul16_seq_pkg::*;
(
  input  logic [MUL_BITS-1:0] a,
  input  logic [MUL_BITS-1:0] b,
  output logic [MUL_BITS-1:0] sum
);

  logic [MUL_BITS-1:0] p;
  logic [MUL_BITS-1:0] g;
  logic [MUL_BITS-1:0] c;

  assign p    = a ^ b;
  assign g    = a & b;
  assign c[0] = 1'b0;

  // Chain stops at bit 15: the sum is modulo 2^16, so the final carry is never needed.
  for (genvar i = 1; i < MUL_BITS; i++) begin : g_carry
    assign c[i] = g[i-1] | (p[i-1] & c[i-1]);
  end

  assign sum = p ^ c;

endmodule

// File: rtl/mul16_seq.sv
// Sequential shift-and-add 16x16 multiplier (low 16 bits) sharing one adder; start/busy/done handshake.
module mul16_seq
  import mul16_seq_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [MUL_BITS-1:0] a,
  input  logic [MUL_BITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [MUL_BITS-1:0] out
);

  state_t              state;
  state_t              state_nx;
  logic [MUL_BITS-1:0] acc;
  logic [MUL_BITS-1:0] mcand;
  logic [MUL_BITS-1:0] mplier;
  logic [4:0]          count;
  logic [MUL_BITS-1:0] sum;
  logic [MUL_BITS-1:0] acc_nx;
  logic                last;

  mul16_seq_add16 u_add16 (
    .a   (acc),
    .b   (mcand),
    .sum (sum)
  );

  assign acc_nx = mplier[0] ? sum : acc;
  // Early exit looks at the multiplier after this cycle's shift: nothing left to add.
  assign last   = (count == 5'd15) ||
                  (EARLY_EXIT && (mplier[MUL_BITS-1:1] == '0));

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (last)  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      out    <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            count  <= '0;
          end
        end
        ST_RUN: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 5'd1;
          if (last) out <= acc_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
// Scoreboard bench: one instance with EARLY_EXIT=0 and one with EARLY_EXIT=1 share all inputs.
module tb_mul16_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy0, done0, busy1, done1;
  logic [15:0] out0, out1;

  int n_pass  = 0;
  int n_total = 0;

  mul16_seq #(.EARLY_EXIT(1'b0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .out(out0)
  );
  mul16_seq #(.EARLY_EXIT(1'b1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1), .out(out1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: product is plain a*b mod 2^16; run length is 16, or with early exit
  // the position of the multiplier's top set bit plus one (at least one).
  function automatic int run_len(input bit ee, input logic [15:0] mb);
    if (!ee) return 16;
    for (int i = 15; i >= 0; i--) if (mb[i]) return i + 1;
    return 1;
  endfunction

  int          m_st  [2];   // 0 idle, 1 running, 2 done
  int          m_rem [2];
  logic [15:0] m_prod[2];
  logic [15:0] m_out [2];
  logic [15:0] sbq0[$];
  logic [15:0] sbq1[$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_rem[i] = 0; m_prod[i] = '0; m_out[i] = '0;
    end
  end

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_st[i] = 0; m_out[i] = '0;
      end else if (m_st[i] == 0) begin
        if (start) begin
          m_st[i]   = 1;
          m_rem[i]  = run_len(i == 1, b);
          m_prod[i] = 16'((32'(a) * 32'(b)) & 32'hFFFF);
          if (i == 0) sbq0.push_back(m_prod[i]);
          else        sbq1.push_back(m_prod[i]);
        end
      end else if (m_st[i] == 1) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_st[i]  = 2;
          m_out[i] = m_prod[i];
        end
      end else begin
        m_st[i] = 0;
      end
    end
    if (reset) begin
      sbq0.delete();
      sbq1.delete();
    end
  end

  // Monitor: every cycle compare handshake and held output, and pop on each done pulse.
  always @(negedge clock) begin
    chk("busy0", 32'(busy0), 32'(m_st[0] == 1));
    chk("done0", 32'(done0), 32'(m_st[0] == 2));
    chk("out0",  32'(out0),  32'(m_out[0]));
    chk("busy1", 32'(busy1), 32'(m_st[1] == 1));
    chk("done1", 32'(done1), 32'(m_st[1] == 2));
    chk("out1",  32'(out1),  32'(m_out[1]));
    if (done0) begin
      if (sbq0.size() == 0) chk("sb0_unexpected_done", 32'(out0), 32'hDEAD_0000);
      else chk("sb0_result", 32'(out0), 32'(sbq0.pop_front()));
    end
    if (done1) begin
      if (sbq1.size() == 0) chk("sb1_unexpected_done", 32'(out1), 32'hDEAD_0000);
      else chk("sb1_result", 32'(out1), 32'(sbq1.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic issue(input logic [15:0] aa, input logic [15:0] bb, input int hold);
    a = aa; b = bb; start = 1'b1;
    tick(hold);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
  endtask

  initial begin
    tick(2);
    chk("reset_out0", 32'(out0), 32'h0);
    chk("reset_busy0", 32'(busy0), 32'h0);
    reset = 1'b0;
    tick(3);
    chk("idle_busy0", 32'(busy0), 32'h0);

    issue(16'h0003, 16'h0005, 1); tick(20);
    chk("mul_3x5", 32'(out0), 32'h000F);
    issue(16'hFFFF, 16'hFFFF, 1); tick(20);
    chk("mul_ffff_sq", 32'(out0), 32'h0001);
    issue(16'h0100, 16'h0100, 1); tick(20);
    chk("mul_wrap", 32'(out0), 32'h0000);
    issue(16'h1234, 16'h0000, 1); tick(20);
    chk("ee_b0", 32'(out1), 32'h0000);
    issue(16'h1234, 16'h0004, 1); tick(20);
    chk("ee_b4", 32'(out1), 32'h48D0);

    // Start pulsed mid-run must not disturb the running operation.
    issue(16'h0007, 16'h0006, 1);
    tick(4);
    issue(16'h0002, 16'h0002, 1);
    tick(20);
    chk("ignored_start", 32'(out0), 32'h002A);

    // Reset during run aborts without a done pulse.
    issue(16'h0011, 16'h0011, 1);
    tick(7);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("abort_busy0", 32'(busy0), 32'h0);
    chk("abort_out0", 32'(out0), 32'h0);
    tick(20);

    for (int n = 0; n < 40; n++) begin
      issue(16'($urandom), 16'($urandom >> $urandom_range(0, 16)), $urandom_range(1, 3));
      tick($urandom_range(17, 22));
    end
    tick(20);
    chk("sb0_drained", 32'(sbq0.size()), 32'h0);
    chk("sb1_drained", 32'(sbq1.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
